// File: rtl/pkt_crc_sequencer.sv
// pkt_crc_sequencer
//   Packet-level controller between the input push interface and the
//   crc32 / 8b10b datapath. Frames packets as K.28.1 sync codes, body bytes,
//   then K.28.5. Drives the CRC engine, and when K.28.5 arrives it emits
//   K.23.7, the four CRC bytes (little endian) and then the K.28.5 itself.
//   After K.28.5 is accepted, a guard window follows. Pushes made during the
//   insert sequence or the guard window are dropped.
//
// Optional feature macro: PKT_SEQ_ERRCHK_EN
//   Defined     : proto_err is a sticky flag. It is set by a push while busy,
//                 a wrong sync count on entry to the body, a K.28.7 input, or
//                 a K.28.5 received in IDLE.
//   Not defined : proto_err is tied to 0 and the checker logic is not built.
//
// Ports
//   clk        in   1   clock, rising edge
//   reset      in   1   asynchronous active-low reset
//   pushin     in   1   input byte valid
//   datain     in   9   {K flag, byte}
//   startin    in   1   first byte of packet, qualified by pushin
//   crc_value  in   32  finalised CRC-32, valid 1 cycle after last crc_en
//   crc_init   out  1   load CRC register with all ones before accumulating
//   crc_en     out  1   accumulate crc_data this cycle
//   crc_data   out  8   byte to CRC
//   enc_push   out  1   byte valid to 8b10b encoder
//   enc_data   out  9   {K flag, byte} to encoder
//   enc_start  out  1   first byte of packet to encoder
//   busy       out  1   inserting CRC or in guard window
//   proto_err  out  1   sticky protocol error flag
module pkt_crc_sequencer #(
  parameter int unsigned SYNC_LEN     = 4,
  parameter int unsigned GUARD_CYCLES = 10,
  parameter logic [8:0]  K281         = 9'h13C,
  parameter logic [8:0]  K285         = 9'h1BC,
  parameter logic [8:0]  K237         = 9'h1F7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pushin,
  input  logic [8:0]  datain,
  input  logic        startin,
  input  logic [31:0] crc_value,
  output logic        crc_init,
  output logic        crc_en,
  output logic [7:0]  crc_data,
  output logic        enc_push,
  output logic [8:0]  enc_data,
  output logic        enc_start,
  output logic        busy,
  output logic        proto_err
);

  localparam int unsigned        GUARD_W   = $clog2(GUARD_CYCLES + 1);
  localparam logic [GUARD_W-1:0] GUARD_MAX = GUARD_W'(GUARD_CYCLES);

  typedef enum logic [3:0] {
    IDLE, SYNC, BODY, INS_K237, INS_C0, INS_C1, INS_C2, INS_C3, INS_EOP, GUARD
  } state_t;

  state_t             state, state_nxt;
  logic [GUARD_W-1:0] guard_cnt, guard_cnt_nxt;
  logic [31:0]        crc_q, crc_q_nxt;
  logic               crc_init_nxt, crc_en_nxt, enc_push_nxt, enc_start_nxt;
  logic [7:0]         crc_data_nxt;
  logic [8:0]         enc_data_nxt;
  logic               is_k281, is_k285;

  always_comb begin
    is_k281 = (datain == K281);
    is_k285 = (datain == K285);
    busy    = !(state inside {IDLE, SYNC, BODY});
  end

  always_comb begin
    state_nxt     = state;
    guard_cnt_nxt = guard_cnt;
    crc_q_nxt     = crc_q;
    crc_init_nxt  = 1'b0;
    crc_en_nxt    = 1'b0;
    crc_data_nxt  = '0;
    enc_push_nxt  = 1'b0;
    enc_data_nxt  = '0;
    enc_start_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (pushin) begin
          enc_push_nxt  = 1'b1;
          enc_data_nxt  = datain;
          enc_start_nxt = startin;
          if (startin && is_k281) state_nxt = SYNC;
        end
      end
      SYNC, BODY: begin
        if (pushin) begin
          if (startin) begin
            // A new start abandons the open packet; its CRC is never emitted.
            enc_push_nxt  = 1'b1;
            enc_data_nxt  = datain;
            enc_start_nxt = 1'b1;
            state_nxt     = is_k281 ? SYNC : IDLE;
          end else if (is_k285) begin
            // K.28.5 is held back and replayed after the CRC bytes.
            state_nxt     = INS_K237;
            guard_cnt_nxt = GUARD_W'(1);
          end else begin
            enc_push_nxt = 1'b1;
            enc_data_nxt = datain;
            if (!is_k281) begin
              crc_en_nxt   = 1'b1;
              crc_data_nxt = datain[7:0];
              if (state == SYNC) begin
                crc_init_nxt = 1'b1;
                state_nxt    = BODY;
              end
            end
          end
        end
      end
      INS_K237: begin
        enc_push_nxt = 1'b1;
        enc_data_nxt = K237;
        crc_q_nxt    = crc_value;
        state_nxt    = INS_C0;
      end
      INS_C0: begin
        enc_push_nxt = 1'b1;
        enc_data_nxt = {1'b0, crc_q[7:0]};
        state_nxt    = INS_C1;
      end
      INS_C1: begin
        enc_push_nxt = 1'b1;
        enc_data_nxt = {1'b0, crc_q[15:8]};
        state_nxt    = INS_C2;
      end
      INS_C2: begin
        enc_push_nxt = 1'b1;
        enc_data_nxt = {1'b0, crc_q[23:16]};
        state_nxt    = INS_C3;
      end
      INS_C3: begin
        enc_push_nxt = 1'b1;
        enc_data_nxt = {1'b0, crc_q[31:24]};
        state_nxt    = INS_EOP;
      end
      INS_EOP: begin
        enc_push_nxt = 1'b1;
        enc_data_nxt = K285;
        state_nxt    = GUARD;
      end
      GUARD: begin
        if (guard_cnt >= GUARD_MAX) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // The guard count runs from K.28.5 acceptance, so it spans the insert states as well.
    if (busy && (guard_cnt < GUARD_MAX)) guard_cnt_nxt = guard_cnt + GUARD_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      guard_cnt <= '0;
      crc_q     <= '0;
      crc_init  <= 1'b0;
      crc_en    <= 1'b0;
      crc_data  <= '0;
      enc_push  <= 1'b0;
      enc_data  <= '0;
      enc_start <= 1'b0;
    end else begin
      state     <= state_nxt;
      guard_cnt <= guard_cnt_nxt;
      crc_q     <= crc_q_nxt;
      crc_init  <= crc_init_nxt;
      crc_en    <= crc_en_nxt;
      crc_data  <= crc_data_nxt;
      enc_push  <= enc_push_nxt;
      enc_data  <= enc_data_nxt;
      enc_start <= enc_start_nxt;
    end
  end

`ifdef PKT_SEQ_ERRCHK_EN
  localparam int unsigned       SYNC_W   = $clog2(SYNC_LEN + 2);
  localparam logic [SYNC_W-1:0] SYNC_EXP = SYNC_W'(SYNC_LEN);
  localparam logic [SYNC_W-1:0] SYNC_SAT = SYNC_W'(SYNC_LEN + 1);
  localparam logic [8:0]        K287     = 9'h1FC;

  logic [SYNC_W-1:0] sync_cnt;
  logic              err_hit;

  always_comb begin
    err_hit = 1'b0;
    if (pushin) begin
      if (busy) err_hit = 1'b1;
      if (datain == K287) err_hit = 1'b1;
      if ((state == IDLE) && is_k285) err_hit = 1'b1;
      if ((state == SYNC) && !startin && !is_k281 && !is_k285 && (sync_cnt != SYNC_EXP))
        err_hit = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_cnt  <= '0;
      proto_err <= 1'b0;
    end else begin
      if (err_hit) proto_err <= 1'b1;
      if (pushin && !busy && startin && is_k281)
        sync_cnt <= SYNC_W'(1);
      else if (pushin && (state == SYNC) && is_k281 && (sync_cnt != SYNC_SAT))
        sync_cnt <= sync_cnt + SYNC_W'(1);
    end
  end
`else
  assign proto_err = 1'b0;
`endif

endmodule
